// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard
//   Decode-side issue scheduler. Tracks in-flight register writes from
//   fixed-latency ops (per-register countdown) and from a single
//   variable-latency mul/div unit (per-register pending bit plus a busy flag).
//   Each cycle it either issues the decode-stage instruction or holds it,
//   reporting the RAW cause on pause = {pause_rt, pause_rs} and structural
//   conflicts on stall_struct.
//
//   Handshake: id_valid presents an instruction; issue is the combinational
//   accept for that same cycle. An instruction is consumed only in a cycle
//   where id_valid & issue are both high; otherwise decode must hold it.
//
//   Optional feature macro: FORWARD_EN -- lets a source whose producer is on
//   the write-back bus this cycle issue without pausing, and reports that
//   operand on fwd_rs_sel / fwd_rt_sel.
module reg_hazard_scoreboard #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic        id_rs_used,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rt_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_we,
  input  logic        id_long,
  input  logic        flush,
  input  logic        long_done,
  input  logic [4:0]  long_rd,
  output logic        issue,
  output logic [1:0]  pause,
  output logic        stall_struct,
  output logic [31:0] pend_mask,
  output logic        fwd_rs_sel,
  output logic        fwd_rt_sel
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      lpend_q, lpend_d;
  logic             long_busy_q, long_busy_d;

  logic [31:0] pend;
  logic [31:0] fwd_ok;
  logic        rs_hit, rt_hit;
  logic        pause_rs, pause_rt;
  logic        done_hits_rd;
  logic        stall_c, issue_c;
  logic        fix_wr, long_wr;

  // Per-register pending view; register 0 is never tracked.
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++) begin
      pend[r] = (cnt_q[r] != '0) | lpend_q[r];
    end
  end

  // Which pending registers can instead be taken from the write-back bus.
  always_comb begin
    fwd_ok = '0;
`ifdef FORWARD_EN
    for (int r = 1; r < 32; r++) begin
      fwd_ok[r] = ((cnt_q[r] == CNT_ONE) & ~lpend_q[r]) |
                  ((cnt_q[r] == '0) & lpend_q[r] & long_done & (long_rd == 5'(r)));
    end
`endif
  end

  // Hazard detection and the combinational issue decision.
  always_comb begin
    rs_hit       = id_valid & id_rs_used & (id_rs_addr != '0) & pend[id_rs_addr];
    rt_hit       = id_valid & id_rt_used & (id_rt_addr != '0) & pend[id_rt_addr];
    pause_rs     = rs_hit & ~fwd_ok[id_rs_addr];
    pause_rt     = rt_hit & ~fwd_ok[id_rt_addr];
    done_hits_rd = long_done & (long_rd == id_rd_addr);
    stall_c      = id_valid &
                   ((id_long & long_busy_q & ~long_done) |
                    (id_rd_we & (id_rd_addr != '0) & lpend_q[id_rd_addr] & ~done_hits_rd));
    issue_c      = id_valid & ~flush & ~pause_rs & ~pause_rt & ~stall_c;
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    issue        = issue_c & ~rst;
    pause        = {pause_rt, pause_rs} & {2{~rst}};
    stall_struct = stall_c & ~rst;
    pend_mask    = pend & {32{~rst}};
    fwd_rs_sel   = rs_hit & fwd_ok[id_rs_addr] & ~rst;
    fwd_rt_sel   = rt_hit & fwd_ok[id_rt_addr] & ~rst;
  end

  // Next scoreboard state: decrement countdowns, then apply new issues (set wins).
  always_comb begin
    fix_wr      = issue_c & id_rd_we & ~id_long & (id_rd_addr != '0);
    long_wr     = issue_c & id_long;
    long_busy_d = long_busy_q;
    if (long_done) long_busy_d = 1'b0;
    if (long_wr)   long_busy_d = 1'b1;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r]   = (cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE : '0;
      lpend_d[r] = lpend_q[r];
      if (fix_wr && (id_rd_addr == 5'(r)))              cnt_d[r]   = CNT_LOAD;
      if (long_done && (long_rd == 5'(r)))              lpend_d[r] = 1'b0;
      if (long_wr && id_rd_we && (id_rd_addr == 5'(r))) lpend_d[r] = 1'b1;
    end
    cnt_d[0]   = '0;
    lpend_d[0] = 1'b0;
  end

  // Scoreboard registers; reset drops every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      lpend_q     <= '0;
      long_busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      lpend_q     <= lpend_d;
      long_busy_q <= long_busy_d;
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb_reg_hazard_scoreboard
//   Directed bench for reg_hazard_scoreboard. A cycle-count based model
//   (each write is "pending until cycle N") predicts every output on every
//   negative edge; per-cycle literal expectations pin the model on the key
//   scenarios. Build with +define+FORWARD_EN to exercise forwarding.
module tb_reg_hazard_scoreboard;

  localparam int PIPE_DEPTH = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        id_valid, id_rs_used, id_rt_used, id_rd_we, id_long, flush, long_done;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, long_rd;
  logic        issue, stall_struct, fwd_rs_sel, fwd_rt_sel;
  logic [1:0]  pause;
  logic [31:0] pend_mask;

  reg_hazard_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_long(id_long),
    .flush(flush), .long_done(long_done), .long_rd(long_rd),
    .issue(issue), .pause(pause), .stall_struct(stall_struct),
    .pend_mask(pend_mask), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  // ---------------- model ----------------
  int cyc = 0;
  int ready_at [32];   // fixed-latency write to r pending while cyc < ready_at[r]
  bit lp [32];         // mul/div write pending
  bit lbusy;

  function automatic bit m_pend(input int r);
    return (r != 0) && ((cyc < ready_at[r]) || lp[r]);
  endfunction

  function automatic bit m_fwd(input int r);
`ifdef FORWARD_EN
    return (r != 0) &&
           (((cyc == ready_at[r] - 1) && !lp[r]) ||
            ((cyc >= ready_at[r]) && lp[r] && long_done && (int'(long_rd) == r)));
`else
    return (r < 0);
`endif
  endfunction

  // ---------------- literal expectations (-1 = don't check) ----------------
  int lit_issue, lit_pause, lit_stall, lit_fwd_rs, lit_fwd_rt, lit_pend_idx, lit_pend_val;
  int lit_pmask_en;
  logic [31:0] lit_pmask;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  logic        e_issue, e_stall, e_frs, e_frt, e_prs, e_prt;
  logic [31:0] e_pmask;

  // Compare process: predict from the model, check DUT and literals, advance model.
  always @(negedge clk) begin
    e_pmask = '0;
    for (int r = 1; r < 32; r++) e_pmask[r] = m_pend(r);
    e_prs   = id_valid && id_rs_used && m_pend(id_rs_addr) && !m_fwd(id_rs_addr);
    e_prt   = id_valid && id_rt_used && m_pend(id_rt_addr) && !m_fwd(id_rt_addr);
    e_frs   = id_valid && id_rs_used && m_pend(id_rs_addr) && m_fwd(id_rs_addr);
    e_frt   = id_valid && id_rt_used && m_pend(id_rt_addr) && m_fwd(id_rt_addr);
    e_stall = id_valid && ((id_long && lbusy && !long_done) ||
              (id_rd_we && id_rd_addr != 0 && lp[id_rd_addr] && !(long_done && long_rd == id_rd_addr)));
    e_issue = id_valid && !flush && !e_prs && !e_prt && !e_stall;
    if (rst) begin
      e_pmask = '0; e_prs = 0; e_prt = 0; e_frs = 0; e_frt = 0; e_stall = 0; e_issue = 0;
    end
    exp_q.push_back({22'd0, e_issue, e_prt, e_prs, e_stall, e_frs, e_frt, 4'd0});
    chk("issue",        32'(issue),        32'(exp_q[0][9]));
    chk("pause",        32'(pause),        32'(exp_q[0][8:7]));
    chk("stall_struct", 32'(stall_struct), 32'(exp_q[0][6]));
    chk("fwd_rs_sel",   32'(fwd_rs_sel),   32'(exp_q[0][5]));
    chk("fwd_rt_sel",   32'(fwd_rt_sel),   32'(exp_q[0][4]));
    chk("pend_mask",    pend_mask,         e_pmask);
    void'(exp_q.pop_front());
    if (lit_issue  >= 0) chk("lit_issue",  32'(issue),        32'(lit_issue));
    if (lit_pause  >= 0) chk("lit_pause",  32'(pause),        32'(lit_pause));
    if (lit_stall  >= 0) chk("lit_stall",  32'(stall_struct), 32'(lit_stall));
    if (lit_fwd_rs >= 0) chk("lit_fwd_rs", 32'(fwd_rs_sel),   32'(lit_fwd_rs));
    if (lit_fwd_rt >= 0) chk("lit_fwd_rt", 32'(fwd_rt_sel),   32'(lit_fwd_rt));
    if (lit_pend_idx >= 0) chk("lit_pend_bit", 32'(pend_mask[lit_pend_idx]), 32'(lit_pend_val));
    if (lit_pmask_en != 0) chk("lit_pmask", pend_mask, lit_pmask);
    // advance model
    if (rst) begin
      for (int r = 0; r < 32; r++) begin ready_at[r] = 0; lp[r] = 0; end
      lbusy = 0;
    end else begin
      if (e_issue && id_rd_we && id_rd_addr != 0 && !id_long)
        ready_at[id_rd_addr] = cyc + PIPE_DEPTH + 1;
      if (long_done) begin
        lp[long_rd] = 0;
        lbusy = 0;
      end
      if (e_issue && id_long) begin
        lbusy = 1;
        if (id_rd_we && id_rd_addr != 0) lp[id_rd_addr] = 1;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [4:0] rs, input bit rsu,
                       input logic [4:0] rt, input bit rtu, input logic [4:0] rd,
                       input bit we, input bit lng, input bit fl, input bit dn,
                       input logic [4:0] drd);
    id_valid = v;   id_rs_addr = rs; id_rs_used = rsu;
    id_rt_addr = rt; id_rt_used = rtu;
    id_rd_addr = rd; id_rd_we = we; id_long = lng;
    flush = fl; long_done = dn; long_rd = drd;
    lit_issue = -1; lit_pause = -1; lit_stall = -1; lit_fwd_rs = -1; lit_fwd_rt = -1;
    lit_pend_idx = -1; lit_pend_val = 0; lit_pmask_en = 0; lit_pmask = '0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < 32; r++) begin ready_at[r] = 0; lp[r] = 0; end
    lbusy = 0;
    rst = 1'b1;
    idle();
    #1;
    // 1: reset with a valid instruction presented
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      lit_issue = 0; lit_pause = 0; lit_stall = 0; lit_pmask_en = 1; lit_pmask = '0;
      tick();
    end
    rst = 1'b0;
    // release: rd=0 write issues but is never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); lit_issue = 1; tick();
    idle(); lit_pmask_en = 1; lit_pmask = '0; tick();

    // 2/3: RAW on r5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); lit_issue = 1; tick();
`ifdef FORWARD_EN
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
      if (i < 2) begin lit_pause = 1; lit_issue = 0; lit_fwd_rs = 0; end
      else       begin lit_pause = 0; lit_issue = 1; lit_fwd_rs = 1; end
      tick();
    end
`else
    for (int i = 0; i < 4; i++) begin
      drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
      if (i < 3) begin lit_pause = 1; lit_issue = 0; end
      else       begin lit_pause = 0; lit_issue = 1; end
      lit_fwd_rs = 0;
      tick();
    end
`endif
    for (int i = 0; i < 4; i++) begin idle(); tick(); end

    // 4: long op rd=8, consumer reads rt=8
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0); lit_issue = 1; tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8, 1, 9, 1, 0, 0, 0, 0);
      lit_pause = 2; lit_issue = 0; lit_stall = 0; lit_pend_idx = 8; lit_pend_val = 1;
      tick();
    end
    drive(1, 0, 0, 8, 1, 9, 1, 0, 0, 1, 8);
`ifdef FORWARD_EN
    lit_issue = 1; lit_pause = 0; lit_fwd_rt = 1; tick();
`else
    lit_issue = 0; lit_pause = 2; lit_fwd_rt = 0; tick();
    drive(1, 0, 0, 8, 1, 9, 1, 0, 0, 0, 0);
    lit_issue = 1; lit_pause = 0; lit_pend_idx = 8; lit_pend_val = 0; tick();
`endif
    // second mul while the unit is busy
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0); lit_issue = 1; tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0);
      lit_stall = 1; lit_issue = 0; lit_pause = 0; tick();
    end
    drive(1, 0, 0, 0, 0, 11, 1, 1, 0, 1, 10); lit_stall = 0; lit_issue = 1; tick();
    idle(); lit_pend_idx = 10; lit_pend_val = 0; tick();
    idle(); lit_pend_idx = 11; lit_pend_val = 1; tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11); tick();
    // stray long_done with nothing pending
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20); tick();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end

    // 5: back-to-back writes to r3 reload the countdown
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); lit_issue = 1; tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); lit_issue = 1; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); lit_pend_idx = 3; lit_pend_val = (i < 3) ? 1 : 0; tick();
    end
    // flush with no hazard
    drive(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0);
    lit_issue = 0; lit_pause = 0; lit_stall = 0; tick();
    idle(); lit_pmask_en = 1; lit_pmask = '0; tick();

    // 6: WAW against a pending mul
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0); lit_issue = 1; tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
      lit_stall = 1; lit_pause = 0; lit_issue = 0; tick();
    end
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 8); lit_stall = 0; lit_issue = 1; tick();
    idle(); lit_pend_idx = 8; lit_pend_val = 1; tick();
    for (int i = 0; i < 4; i++) begin idle(); tick(); end

    // reset mid-operation drops pending entries
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); lit_issue = 1; tick();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0); lit_issue = 1; tick();
    rst = 1'b1;
    idle(); lit_pmask_en = 1; lit_pmask = '0; tick();
    rst = 1'b0;
    drive(1, 7, 1, 9, 1, 4, 1, 0, 0, 0, 0);
    lit_pmask_en = 1; lit_pmask = '0; lit_issue = 1; lit_pause = 0; tick();
    for (int i = 0; i < 5; i++) begin idle(); tick(); end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
